// File: rtl/r6_stage_ctrl_if.sv
// Handshake/status bundle for the r6 stage controller.
// Ports: start/abort/in_valid in; in_ready, sel_bf, tw_addr, buf_vld, busy, frame_done, abort_err out.
interface r6_stage_ctrl_if #(
  parameter int CW = 6
);
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic          sel_bf;
  logic [CW-1:0] tw_addr;
  logic          buf_vld;
  logic          busy;
  logic          frame_done;
  logic          abort_err;

  modport master (
    output start, abort, in_valid,
    input  in_ready, sel_bf, tw_addr, buf_vld,
    input  busy, frame_done, abort_err
  );

  modport slave (
    input  start, abort, in_valid,
    output in_ready, sel_bf, tw_addr, buf_vld,
    output busy, frame_done, abort_err
  );
endinterface

// File: rtl/r6_stage_ctrl.sv
// Radix stage controller: frame sequencing, sample count, phase/twiddle, delay-valid tracking.
// Ports: clk, rst (async high), s = slave side of r6_stage_ctrl_if (all outputs registered).
module r6_stage_ctrl #(
  parameter int FRAME_LEN = 36,
  parameter int DLY       = 8,
  parameter int CW        = 6
) (
  input logic           clk,
  input logic           rst,
  r6_stage_ctrl_if.slave s
);
  localparam int PW = (DLY > 1) ? $clog2(DLY) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic           ph_q, ph_d;
  logic [DLY-1:0] sr_q, sr_d;
  logic           abt_q, abt_d;
  logic           rdy_q, rdy_d;
  logic           sel_q, sel_d;
  logic [CW-1:0]  tw_q, tw_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           accept;
  logic           last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    ph_d    = ph_q;
    abt_d   = abt_q;
    sel_d   = sel_q;
    tw_d    = tw_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    accept  = s.in_valid & rdy_q;
    last    = accept && (cnt_q == CW'(FRAME_LEN - 1));
    // low DLY bits of {sr, accept} = one-place left shift
    sr_d    = DLY'({sr_q, accept});

    unique case (state_q)
      IDLE: begin
        if (s.start) begin
          state_d = RUN;
          cnt_d   = '0;
          pcnt_d  = '0;
          ph_d    = 1'b0;
          abt_d   = 1'b0;
        end
      end
      RUN: begin
        if (s.abort) begin
          state_d = DRAIN;
          err_d   = 1'b1;
          abt_d   = 1'b1;
        end else if (last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // leave once the buffer will be empty next cycle
        if (sr_d == '0) begin
          state_d = IDLE;
          done_d  = ~abt_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      sel_d = ph_q;
      tw_d  = ph_q ? cnt_q : '0;
      if (pcnt_q == PW'(DLY - 1)) begin
        pcnt_d = '0;
        ph_d   = ~ph_q;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    rdy_d  = (state_d == RUN);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      ph_q    <= 1'b0;
      sr_q    <= '0;
      abt_q   <= 1'b0;
      rdy_q   <= 1'b0;
      sel_q   <= 1'b0;
      tw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      ph_q    <= ph_d;
      sr_q    <= sr_d;
      abt_q   <= abt_d;
      rdy_q   <= rdy_d;
      sel_q   <= sel_d;
      tw_q    <= tw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s.in_ready   = rdy_q;
  assign s.sel_bf     = sel_q;
  assign s.tw_addr    = tw_q;
  assign s.buf_vld    = sr_q[DLY-1];
  assign s.busy       = busy_q;
  assign s.frame_done = done_q;
  assign s.abort_err  = err_q;
endmodule
